mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing port B of the CPU's synchronous data memory between the CPU control FSM's load/store sequencing (requester 0) and a secondary bus master such as display or I/O fetch (requester 1). Each accepted request issues one memory access cycle; read data comes back one cycle later with a per-requester valid strobe. By default requester 0 has fixed priority. A compile-time starvation guard can bound how long requester 1 waits.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares port B of the CPU's synchronous data memory between two requesters:
// requester 0 (CPU load/store sequencing) and requester 1 (secondary bus
// master). Each grant issues one memory access cycle; read data returns one
// cycle later with a per-requester valid strobe. Requester 0 has fixed
// priority unless the optional starvation guard is compiled in.
//
// Optional feature macro: STARVE_GUARD_EN
//   Defined   -> 4-bit wait counter forces a requester-1 grant after
//                STARVE_LIMIT consecutive requester-0 grants while req1 waits.
//   Undefined -> pure fixed priority, requester 1 may starve.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN  request, write enable, address, write data (N=0,1)
//   gntN                registered grant pulse (access on memory port now)
//   rvalidN             registered read-data-valid pulse
//   rdata               read data, taken from mem_rdata while an rvalid is high
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory port controls
//   mem_rdata           memory read data, valid the cycle after a read
module mem_port_arbiter #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Reject an out-of-range limit at elaboration time.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                gnt0_d, gnt1_d;
    logic                rvalid0_d, rvalid1_d;
    logic                mem_en_d, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic                override_c;

`ifdef STARVE_GUARD_EN
    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Requester 1 has waited through the tolerated number of requester-0 grants.
    assign override_c = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // Wait counter: only moves at IDLE evaluations, saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (!req1 || state_d == ACC1) begin
                starve_cnt_d = '0;
            end else if (state_d == ACC0 && starve_cnt_q < CNT_W'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign override_c = 1'b0;
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state_q)
            IDLE: begin
                // Override only matters if requester 1 is actually waiting.
                if (req0 && !(override_c && req1)) begin
                    state_d     = ACC0;
                    gnt0_d      = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we0;
                    mem_addr_d  = addr0;
                    mem_wdata_d = wdata0;
                end else if (req1) begin
                    state_d     = ACC1;
                    gnt1_d      = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we1;
                    mem_addr_d  = addr1;
                    mem_wdata_d = wdata1;
                end
            end
            ACC0: begin
                state_d   = IDLE;
                rvalid0_d = !mem_we;
            end
            ACC1: begin
                state_d   = IDLE;
                rvalid1_d = !mem_we;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            rvalid0   <= rvalid0_d;
            rvalid1   <= rvalid1_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Memory data arrives in the rvalid cycle itself, so it is passed through
    // gated by the registered strobes rather than registered again.
    assign rdata = (rvalid0 || rvalid1) ? mem_rdata : DATA_W'(0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small synchronous
// memory model on the memory port.
module tb_mem_port_arbiter;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
`ifdef STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req0(req0),
        .we0(we0),
        .addr0(addr0),
        .wdata0(wdata0),
        .req1(req1),
        .we1(we1),
        .addr1(addr1),
        .wdata1(wdata1),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .rvalid0(rvalid0),
        .rvalid1(rvalid1),
        .rdata(rdata),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data valid the cycle after the access.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h040] = 16'hBEEF;
        mem_rdata = '0;

        // Reset held with every request asserted.
        reset  = 1'b0;
        req0   = 1'b1; we0 = 1'b0; addr0 = 16'h0040; wdata0 = 16'h0;
        req1   = 1'b1; we1 = 1'b1; addr1 = 16'h0100; wdata1 = 16'h1234;
        tick(); tick(); tick();
        chk("rst_gnt0",      32'(gnt0),      32'h0);
        chk("rst_gnt1",      32'(gnt1),      32'h0);
        chk("rst_mem_en",    32'(mem_en),    32'h0);
        chk("rst_mem_we",    32'(mem_we),    32'h0);
        chk("rst_rvalid0",   32'(rvalid0),   32'h0);
        chk("rst_rvalid1",   32'(rvalid1),   32'h0);
        chk("rst_mem_addr",  32'(mem_addr),  32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_rdata",     32'(rdata),     32'h0);

        // Release reset with only requester 0 reading 0x0040.
        reset = 1'b1;
        req1  = 1'b0;
        tick();
        chk("rd_gnt0",     32'(gnt0),     32'h1);
        chk("rd_gnt1",     32'(gnt1),     32'h0);
        chk("rd_mem_en",   32'(mem_en),   32'h1);
        chk("rd_mem_we",   32'(mem_we),   32'h0);
        chk("rd_mem_addr", 32'(mem_addr), 32'h0040);
        req0 = 1'b0;
        tick();
        chk("rd_rvalid0",  32'(rvalid0),  32'h1);
        chk("rd_rvalid1",  32'(rvalid1),  32'h0);
        chk("rd_rdata",    32'(rdata),    32'hBEEF);
        chk("rd_gnt0_low", 32'(gnt0),     32'h0);
        chk("rd_en_low",   32'(mem_en),   32'h0);
        chk("rd_addr_hold",32'(mem_addr), 32'h0040);

        // Requester 1 writes 0x1234 to 0x0100.
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0100; wdata1 = 16'h1234;
        tick();
        chk("wr_gnt1",      32'(gnt1),      32'h1);
        chk("wr_gnt0",      32'(gnt0),      32'h0);
        chk("wr_mem_we",    32'(mem_we),    32'h1);
        chk("wr_mem_addr",  32'(mem_addr),  32'h0100);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
        req1 = 1'b0;
        tick();
        chk("wr_no_rvalid0", 32'(rvalid0), 32'h0);
        chk("wr_no_rvalid1", 32'(rvalid1), 32'h0);
        chk("wr_we_low",     32'(mem_we),  32'h0);

        // Read the written word back through requester 0.
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100;
        tick();
        chk("rb_gnt0", 32'(gnt0), 32'h1);
        req0 = 1'b0;
        tick();
        chk("rb_rvalid0", 32'(rvalid0), 32'h1);
        chk("rb_rdata",   32'(rdata),   32'h1234);

        // Contention: both request reads in the same cycle.
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0100;
        tick();
        chk("ct_c1_gnt0", 32'(gnt0), 32'h1);
        chk("ct_c1_gnt1", 32'(gnt1), 32'h0);
        req0 = 1'b0;
        tick();
        chk("ct_c2_gnt0",    32'(gnt0),    32'h0);
        chk("ct_c2_gnt1",    32'(gnt1),    32'h0);
        chk("ct_c2_rvalid0", 32'(rvalid0), 32'h1);
        chk("ct_c2_rdata",   32'(rdata),   32'hBEEF);
        tick();
        chk("ct_c3_gnt0", 32'(gnt0), 32'h0);
        chk("ct_c3_gnt1", 32'(gnt1), 32'h1);
        chk("ct_c3_addr", 32'(mem_addr), 32'h0100);
        req1 = 1'b0;
        tick();
        chk("ct_c4_rvalid1", 32'(rvalid1), 32'h1);
        chk("ct_c4_rvalid0", 32'(rvalid0), 32'h0);
        chk("ct_c4_rdata",   32'(rdata),   32'h1234);

        // Starvation: requester 0 keeps writing, requester 1 waits to read.
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0200; wdata0 = 16'h5555;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0040;
        for (int i = 1; i <= 12; i++) begin
            logic e0, e1;
            tick();
            e1 = GUARD && (i == 9);
            e0 = (i % 2 == 1) && !e1;
            chk($sformatf("st_c%0d_gnt0", i), 32'(gnt0), 32'(e0));
            chk($sformatf("st_c%0d_gnt1", i), 32'(gnt1), 32'(e1));
            if (gnt1) req1 = 1'b0;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();

        // Reset during ACC0 of a read.
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
        tick();
        chk("ra_gnt0",   32'(gnt0),   32'h1);
        chk("ra_mem_en", 32'(mem_en), 32'h1);
        req0 = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("ra_mem_en_drop", 32'(mem_en), 32'h0);
        chk("ra_mem_we_drop", 32'(mem_we), 32'h0);
        chk("ra_gnt0_drop",   32'(gnt0),   32'h0);
        tick();
        chk("ra_no_rvalid0_rst", 32'(rvalid0), 32'h0);
        reset = 1'b1;
        tick();
        chk("ra_no_rvalid0", 32'(rvalid0), 32'h0);
        chk("ra_idle_gnt0",  32'(gnt0),    32'h0);
        // Immediate grant after release shows the FSM sat in IDLE.
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0100;
        tick();
        chk("ra_post_gnt1", 32'(gnt1), 32'h1);
        req1 = 1'b0;
        tick();
        chk("ra_post_rvalid1", 32'(rvalid1), 32'h1);
        chk("ra_post_rdata",   32'(rdata),   32'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
